// File: rtl/vx_tcu_drl_mul_pipe.sv
// TCU DRL shared multiplier stage: per-slot FP16/BF16/I8/U8 partial products,
// C-term packing, FP exception flags and a tag sideband, carried through an
// elastic valid/ready pipe of LATENCY register stages with a global stall.
module vx_tcu_drl_mul_pipe #(
    parameter int unsigned N       = 2,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 8,
    localparam int unsigned TCK    = 2 * N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [3:0]              fmt_s,
    input  logic [TCK-1:0]          vld_mask,
    input  logic [N*32-1:0]         a_row,
    input  logic [N*32-1:0]         b_col,
    input  logic [31:0]             c_val,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [(TCK+1)*25-1:0]   y,
    output logic                    exc_nan,
    output logic                    exc_inf,
    output logic [TAG_W-1:0]        tag_out
);

    localparam int unsigned YW = (TCK + 1) * 25;
    localparam int unsigned PW = TAG_W + 2 + YW;

    // Format IDs shared with the TCU package
    localparam logic [3:0] FMT_FP16 = 4'd1;
    localparam logic [3:0] FMT_BF16 = 4'd2;
    localparam logic [3:0] FMT_I8   = 4'd9;
    localparam logic [3:0] FMT_U8   = 4'd10;

    // Returns {zero, inf, nan, mantissa[10:0]}; BF16 mantissa sits in bits [7:0]
    function automatic logic [13:0] classify(input logic [15:0] h, input logic bf);
        logic       sub;
        logic       exp_ones;
        logic [9:0] frac;
        logic       zero;
        logic       inf;
        logic       nan;
        logic [10:0] mant;
        if (bf) begin
            sub      = (h[14:7] == 8'd0);
            exp_ones = &h[14:7];
            frac     = {3'b000, h[6:0]};
        end else begin
            sub      = (h[14:10] == 5'd0);
            exp_ones = &h[14:10];
            frac     = h[9:0];
        end
        zero = sub && (frac == 10'd0);
        inf  = exp_ones && (frac == 10'd0);
        nan  = exp_ones && (frac != 10'd0);
        if (zero)
            mant = 11'd0;
        else if (bf)
            mant = {3'b000, !sub, h[6:0]};
        else
            mant = {!sub, h[9:0]};
        return {zero, inf, nan, mant};
    endfunction

    // Returns {nan_flag, inf_flag, y_slot[24:0]} for one 16-bit half pair
    function automatic logic [26:0] slot_calc(input logic [3:0] fmt, input logic [15:0] ha,
                                              input logic [15:0] hb, input logic act);
        logic        is_bf;
        logic        is_fp;
        logic [13:0] ca;
        logic [13:0] cb;
        logic [21:0] prod;
        logic        sgn;
        logic [16:0] sa0, sa1, sb0, sb1;
        logic [16:0] s_sum;
        logic [16:0] u_sum;
        logic [24:0] ys;
        logic        nan;
        logic        inf;
        is_bf = (fmt == FMT_BF16);
        is_fp = (fmt == FMT_FP16) || is_bf;
        ca    = classify(ha, is_bf);
        cb    = classify(hb, is_bf);
        prod  = 22'(ca[10:0]) * 22'(cb[10:0]);
        sgn   = ha[15] ^ hb[15];
        sa0   = {{9{ha[7]}}, ha[7:0]};
        sa1   = {{9{ha[15]}}, ha[15:8]};
        sb0   = {{9{hb[7]}}, hb[7:0]};
        sb1   = {{9{hb[15]}}, hb[15:8]};
        s_sum = sa0 * sb0 + sa1 * sb1;
        u_sum = 17'(ha[7:0]) * 17'(hb[7:0]) + 17'(ha[15:8]) * 17'(hb[15:8]);
        ys    = 25'd0;
        nan   = 1'b0;
        inf   = 1'b0;
        if (act) begin
            case (fmt)
                FMT_FP16: ys = {sgn, prod, 2'b00};
                FMT_BF16: ys = {sgn, prod[15:0], 8'h00};
                FMT_I8:   ys = {{8{s_sum[16]}}, s_sum};
                FMT_U8:   ys = {8'h00, u_sum};
                default:  ys = 25'd0;
            endcase
            if (is_fp) begin
                nan = ca[11] | cb[11] | (ca[12] & cb[13]) | (ca[13] & cb[12]);
                inf = ca[12] | cb[12];
            end
        end
        return {nan, inf, ys};
    endfunction

    logic               en;
    logic [YW-1:0]      comb_y;
    logic               comb_nan;
    logic               comb_inf;
    logic [26:0]        slot_r;
    logic [PW-1:0]      data_d;
    logic [LATENCY-1:0] vld_q;
    logic [PW-1:0]      data_q [LATENCY];
    logic               unused_c_bits;

    // Whole pipe advances together; a held output freezes every stage
    assign en       = !vld_q[LATENCY-1] || ready_out;
    assign ready_in = en;

    // Slot products, flag reduction and C-term packing for the incoming beat
    always_comb begin
        comb_y   = '0;
        comb_nan = 1'b0;
        comb_inf = 1'b0;
        slot_r   = '0;
        for (int i = 0; i < int'(TCK); i++) begin
            slot_r = slot_calc(fmt_s, a_row[(i/2)*32 + (i%2)*16 +: 16],
                               b_col[(i/2)*32 + (i%2)*16 +: 16], vld_mask[i]);
            comb_y[i*25 +: 25] = slot_r[24:0];
            comb_nan = comb_nan | slot_r[26];
            comb_inf = comb_inf | slot_r[25];
        end
        comb_y[TCK*25 +: 25] = fmt_s[3] ? c_val[24:0] : {c_val[31], 1'b1, c_val[22:0]};
    end

    assign data_d        = {tag_in, comb_nan, comb_inf, comb_y};
    assign unused_c_bits = ^c_val[30:25];

    // Stage registers: reset flushes every beat, en gates all movement
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 0; s < int'(LATENCY); s++)
                data_q[s] <= '0;
        end else if (en) begin
            vld_q[0]  <= valid_in;
            data_q[0] <= data_d;
            for (int s = 1; s < int'(LATENCY); s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign valid_out = vld_q[LATENCY-1];
    assign {tag_out, exc_nan, exc_inf, y} = data_q[LATENCY-1];

endmodule

// File: tb/tb_vx_tcu_drl_mul_pipe.sv
// Self-checking bench for vx_tcu_drl_mul_pipe: scoreboard of expected beats
// filled on acceptance and drained by an output monitor, plus directed checks.
module tb_vx_tcu_drl_mul_pipe;

    localparam int unsigned N       = 2;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned TCK     = 2 * N;
    localparam int unsigned YW      = (TCK + 1) * 25;

    localparam logic [3:0] FP16 = 4'd1;
    localparam logic [3:0] BF16 = 4'd2;
    localparam logic [3:0] I8   = 4'd9;
    localparam logic [3:0] U8   = 4'd10;

    typedef struct packed {
        logic [YW-1:0]    y;
        logic             nan;
        logic             inf;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               valid_in;
    logic               ready_in;
    logic [3:0]         fmt_s;
    logic [TCK-1:0]     vld_mask;
    logic [N*32-1:0]    a_row;
    logic [N*32-1:0]    b_col;
    logic [31:0]        c_val;
    logic [TAG_W-1:0]   tag_in;
    logic               valid_out;
    logic               ready_out;
    logic [YW-1:0]      y;
    logic               exc_nan;
    logic               exc_inf;
    logic [TAG_W-1:0]   tag_out;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    vx_tcu_drl_mul_pipe #(.N(N), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .fmt_s(fmt_s), .vld_mask(vld_mask), .a_row(a_row), .b_col(b_col),
        .c_val(c_val), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
        .y(y), .exc_nan(exc_nan), .exc_inf(exc_inf), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference for one slot, written with integer arithmetic
    function automatic logic [26:0] model_slot(input logic [3:0] fmt, input logic [15:0] ha,
                                               input logic [15:0] hb, input logic m);
        int ea, fa, eb, fb, ma, mb, p, s, ebits, fbits, emax;
        int a0, a1, b0, b1;
        logic az, ai, an, bz, bi, bn, nan, inf, sgn;
        logic [24:0] yy;
        yy  = '0;
        nan = 1'b0;
        inf = 1'b0;
        sgn = ha[15] ^ hb[15];
        if (!m) return 27'd0;
        if (fmt == FP16 || fmt == BF16) begin
            fbits = (fmt == FP16) ? 10 : 7;
            ebits = (fmt == FP16) ? 5 : 8;
            emax  = (1 << ebits) - 1;
            ea = (int'(ha[14:0]) >> fbits) & emax;
            eb = (int'(hb[14:0]) >> fbits) & emax;
            fa = int'(ha) & ((1 << fbits) - 1);
            fb = int'(hb) & ((1 << fbits) - 1);
            az = (ea == 0 && fa == 0);
            bz = (eb == 0 && fb == 0);
            ai = (ea == emax && fa == 0);
            bi = (eb == emax && fb == 0);
            an = (ea == emax && fa != 0);
            bn = (eb == emax && fb != 0);
            ma = az ? 0 : (((ea != 0) ? 1 : 0) << fbits) | fa;
            mb = bz ? 0 : (((eb != 0) ? 1 : 0) << fbits) | fb;
            p  = ma * mb;
            if (fmt == FP16) yy = {sgn, 24'(p * 4)};
            else             yy = {sgn, 24'((p & 32'hFFFF) * 256)};
            nan = an | bn | (ai & bz) | (az & bi);
            inf = ai | bi;
        end else if (fmt == I8) begin
            a0 = int'($signed(ha[7:0]));  a1 = int'($signed(ha[15:8]));
            b0 = int'($signed(hb[7:0]));  b1 = int'($signed(hb[15:8]));
            s  = a0 * b0 + a1 * b1;
            yy = 25'(s);
        end else if (fmt == U8) begin
            s  = int'(ha[7:0]) * int'(hb[7:0]) + int'(ha[15:8]) * int'(hb[15:8]);
            yy = 25'(s);
        end
        return {nan, inf, yy};
    endfunction

    function automatic exp_t model(input logic [3:0] fmt, input logic [TCK-1:0] m,
                                   input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                                   input logic [31:0] c, input logic [TAG_W-1:0] t);
        exp_t e;
        logic [26:0] r;
        e = '0;
        for (int i = 0; i < int'(TCK); i++) begin
            r = model_slot(fmt, a[i*16 +: 16], b[i*16 +: 16], m[i]);
            e.y[i*25 +: 25] = r[24:0];
            e.nan = e.nan | r[26];
            e.inf = e.inf | r[25];
        end
        e.y[TCK*25 +: 25] = fmt[3] ? c[24:0] : {c[31], 1'b1, c[22:0]};
        e.tag = t;
        return e;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] sp [8];
        sp = '{16'h0000, 16'h7C00, 16'h7F80, 16'h7E00, 16'h7FC0, 16'h8000, 16'h0001, 16'h0080};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    // Output monitor: every consumed beat is checked against the scoreboard head
    always @(negedge clk) begin
        if (reset === 1'b0 && valid_out === 1'b1 && ready_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat got tag=%0h y=%h want no beat", tag_out, y);
            end else begin
                mon_e = sb.pop_front();
                if (y !== mon_e.y) begin
                    failures++;
                    $display("FAIL beat_y tag=%0h got %h want %h", mon_e.tag, y, mon_e.y);
                end
                checks++;
                if (exc_nan !== mon_e.nan) begin
                    failures++;
                    $display("FAIL beat_nan tag=%0h got %b want %b", mon_e.tag, exc_nan, mon_e.nan);
                end
                checks++;
                if (exc_inf !== mon_e.inf) begin
                    failures++;
                    $display("FAIL beat_inf tag=%0h got %b want %b", mon_e.tag, exc_inf, mon_e.inf);
                end
                checks++;
                if (tag_out !== mon_e.tag) begin
                    failures++;
                    $display("FAIL beat_tag got %h want %h", tag_out, mon_e.tag);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat until accepted, then record its expected result
    task automatic drive_beat(input logic [3:0] fmt, input logic [TCK-1:0] m,
                              input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                              input logic [31:0] c, input logic [TAG_W-1:0] t);
        bit ok;
        fmt_s = fmt; vld_mask = m; a_row = a; b_col = b; c_val = c; tag_in = t;
        valid_in = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ready_in === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (ok) sb.push_back(model(fmt, m, a, b, c, t));
        else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tag=%0h got ready_in=%b want 1", t, ready_in);
        end
    endtask

    // Cycles from acceptance until valid_out rises (1 = visible right after accept edge)
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (valid_out !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", valid_out); end
        checks++; if (y !== '0)           begin failures++; $display("FAIL rst_y got %h want 0", y); end
        checks++; if (exc_nan !== 1'b0)   begin failures++; $display("FAIL rst_nan got %b want 0", exc_nan); end
        checks++; if (exc_inf !== 1'b0)   begin failures++; $display("FAIL rst_inf got %b want 0", exc_inf); end
        checks++; if (tag_out !== '0)     begin failures++; $display("FAIL rst_tag got %h want 0", tag_out); end
        reset = 1'b0;
        idle(1);
        checks++; if (ready_in !== 1'b1)  begin failures++; $display("FAIL rst_ready got %b want 1", ready_in); end
    endtask

    task automatic test_fp16();
        int cyc;
        drive_beat(FP16, 4'hF, {2{32'h3E00_3E00}}, {2{32'h4000_4000}}, 32'h0, 8'h11);
        wait_valid(cyc);
        checks++; if (cyc != int'(LATENCY)) begin failures++; $display("FAIL fp16_latency got %0d want %0d", cyc, LATENCY); end
        for (int i = 0; i < int'(TCK); i++) begin
            checks++;
            if (y[i*25 +: 25] !== 25'h0600000) begin
                failures++; $display("FAIL fp16_slot%0d got %h want 0600000", i, y[i*25 +: 25]);
            end
        end
        checks++; if (exc_nan !== 1'b0 || exc_inf !== 1'b0) begin failures++; $display("FAIL fp16_flags got %b%b want 00", exc_nan, exc_inf); end
        idle(LATENCY + 1);
    endtask

    task automatic test_bf16();
        int cyc;
        drive_beat(BF16, 4'hF, {2{32'h3F80_3F80}}, {2{32'hBF80_BF80}}, 32'h4040_0000, 8'h21);
        drive_beat(BF16, 4'hF, {2{32'h7F80_7F80}}, {2{32'h0000_0000}}, 32'h0, 8'h22);
        wait_valid(cyc);
        checks++; if (y[24:0] !== 25'h1400000) begin failures++; $display("FAIL bf16_neg got %h want 1400000", y[24:0]); end
        idle(1);
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL bf16_b2b_valid got %b want 1", valid_out); end
        checks++; if (exc_inf !== 1'b1)   begin failures++; $display("FAIL bf16_inf got %b want 1", exc_inf); end
        checks++; if (exc_nan !== 1'b1)   begin failures++; $display("FAIL bf16_inf_x_zero got %b want 1", exc_nan); end
        idle(LATENCY + 1);
    endtask

    task automatic test_int();
        int cyc;
        drive_beat(I8, 4'hF, {2{32'hFD05_FD05}}, {2{32'h07FE_07FE}}, 32'h0012_3456, 8'h31);
        drive_beat(U8, 4'hF, {2{32'hFFFF_FFFF}}, {2{32'hFFFF_FFFF}}, 32'h0, 8'h32);
        wait_valid(cyc);
        checks++; if (y[24:0] !== 25'h1FFFFE1) begin failures++; $display("FAIL i8_dot got %h want 1FFFFE1", y[24:0]); end
        checks++; if (y[TCK*25 +: 25] !== 25'h0123456) begin failures++; $display("FAIL i8_cterm got %h want 0123456", y[TCK*25 +: 25]); end
        idle(1);
        checks++; if (y[75 +: 25] !== 25'h001FC02) begin failures++; $display("FAIL u8_dot got %h want 001FC02", y[75 +: 25]); end
        idle(LATENCY + 1);
    endtask

    task automatic test_mask();
        int cyc;
        // Slots 1 and 3 carry NaN operands but are disabled
        drive_beat(FP16, 4'b0101, {2{32'h7E00_3E00}}, {2{32'h4000_4000}}, 32'h3F80_0000, 8'h41);
        drive_beat(FP16, 4'b1111, {2{32'h7E00_3E00}}, {2{32'h4000_4000}}, 32'h3F80_0000, 8'h42);
        wait_valid(cyc);
        checks++; if (y[25 +: 25] !== 25'h0) begin failures++; $display("FAIL mask_slot1 got %h want 0", y[25 +: 25]); end
        checks++; if (y[75 +: 25] !== 25'h0) begin failures++; $display("FAIL mask_slot3 got %h want 0", y[75 +: 25]); end
        checks++; if (y[50 +: 25] !== 25'h0600000) begin failures++; $display("FAIL mask_slot2 got %h want 0600000", y[50 +: 25]); end
        checks++; if (exc_nan !== 1'b0) begin failures++; $display("FAIL mask_nan got %b want 0", exc_nan); end
        // C = 1.0: sign 0, implicit one at bit 23, fraction 0
        checks++; if (y[TCK*25 +: 25] !== 25'h0800000) begin failures++; $display("FAIL cterm_fp got %h want 0800000", y[TCK*25 +: 25]); end
        idle(1);
        checks++; if (exc_nan !== 1'b1 || exc_inf !== 1'b0) begin failures++; $display("FAIL unmask_flags got %b%b want 10", exc_nan, exc_inf); end
        idle(LATENCY + 1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] fmt_tab [5];
        logic [N*32-1:0] a, b;
        fmt_tab = '{FP16, BF16, I8, U8, 4'd0};
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < int'(TCK); i++) begin
                a[i*16 +: 16] = rand_half();
                b[i*16 +: 16] = rand_half();
            end
            drive_beat(fmt_tab[$urandom_range(0, 4)], TCK'($urandom), a, b, $urandom, TAG_W'(8'h80 + n));
        end
        for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        bit          sent;
        bit          finished;
        bit          prev_stall;
        logic [YW-1:0]    prev_y;
        logic [TAG_W-1:0] prev_tag;
        int          exp_tag;
        logic [N*32-1:0] a, b;
        sent = 0; finished = 0; prev_stall = 0; exp_tag = 0;
        prev_y = '0; prev_tag = '0;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    for (int i = 0; i < int'(TCK); i++) begin
                        a[i*16 +: 16] = rand_half();
                        b[i*16 +: 16] = rand_half();
                    end
                    drive_beat(FP16, 4'hF, a, b, 32'h0, TAG_W'(t));
                end
                sent = 1;
            end
            begin
                for (int k = 0; k < 300 && !(sent && sb.size() == 0 && valid_out !== 1'b1); k++) begin
                    ready_out = (k % 4 == 0) || (k % 4 == 3);
                    idle(1);
                end
                ready_out = 1'b1;
                finished = 1;
            end
            begin
                while (!finished) begin
                    @(negedge clk);
                    checks++;
                    if (ready_in !== !(valid_out && !ready_out)) begin
                        failures++;
                        $display("FAIL bp_ready_in got %b want %b", ready_in, !(valid_out && !ready_out));
                    end
                    if (prev_stall) begin
                        checks++;
                        if (valid_out !== 1'b1 || y !== prev_y || tag_out !== prev_tag) begin
                            failures++;
                            $display("FAIL bp_hold got v=%b tag=%h want v=1 tag=%h", valid_out, tag_out, prev_tag);
                        end
                    end
                    if (valid_out === 1'b1 && ready_out === 1'b1) begin
                        checks++;
                        if (tag_out !== TAG_W'(exp_tag)) begin
                            failures++;
                            $display("FAIL bp_order got %0d want %0d", tag_out, exp_tag);
                        end
                        exp_tag++;
                    end
                    prev_stall = (valid_out === 1'b1) && (ready_out === 1'b0);
                    prev_y     = y;
                    prev_tag   = tag_out;
                end
            end
        join
        checks++; if (exp_tag != 8) begin failures++; $display("FAIL bp_count got %0d want 8", exp_tag); end
        idle(2);
    endtask

    task automatic test_reset_flush();
        int cyc;
        int stale;
        ready_out = 1'b0;
        for (int s = 0; s < int'(LATENCY); s++)
            drive_beat(FP16, 4'hF, {2{32'h3E00_3E00}}, {2{32'h4000_4000}}, 32'h0, TAG_W'(8'hA0 + s));
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL flush_full got %b want 1", valid_out); end
        reset = 1'b1;
        valid_in = 1'b1;
        fmt_s = FP16; vld_mask = '1; a_row = {2{32'h3C00_3C00}}; b_col = {2{32'h3C00_3C00}};
        tag_in = 8'hEE;
        sb.delete();
        idle(1);
        reset = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", valid_out); end
        checks++; if (y !== '0) begin failures++; $display("FAIL flush_y got %h want 0", y); end
        checks++; if (tag_out !== '0 || exc_nan !== 1'b0 || exc_inf !== 1'b0) begin
            failures++; $display("FAIL flush_side got tag=%h f=%b%b want 0", tag_out, exc_nan, exc_inf);
        end
        stale = 0;
        repeat (LATENCY + 4) begin
            if (valid_out !== 1'b0) stale++;
            idle(1);
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL flush_stale got %0d beats want 0", stale); end
        drive_beat(U8, 4'hF, {2{32'h0102_0304}}, {2{32'h0506_0708}}, 32'h0, 8'h55);
        wait_valid(cyc);
        checks++; if (cyc != int'(LATENCY)) begin failures++; $display("FAIL flush_latency got %0d want %0d", cyc, LATENCY); end
        idle(LATENCY + 1);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; fmt_s = '0; vld_mask = '0; a_row = '0; b_col = '0;
        c_val = '0; tag_in = '0; ready_out = 1'b1;
        test_reset();
        test_fp16();
        test_bf16();
        test_int();
        test_mask();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
